fft_stage_ctrl: RTL and testbench

- Upstream controller for the radix-2 butterfly in the in-place, ping-pong-RAM FFT core.
- Sequences every stage and butterfly of an N = 2^ADDR_WIDTH point DIT FFT.
- Drives RAM read addresses, twiddle ROM address, the butterfly sync-address bus (m_in) and the write-back strobe.
- Input data is assumed already bit-reversed in bank 0 by the loader.

---
 rtl/fft_stage_ctrl.sv | 133 +++++++++++++
 tb/tb_fft_stage_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT over ping-pong RAM banks.
// Issues one butterfly per cycle, then drains the butterfly pipeline before the next stage.
module fft_stage_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned BF_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH-1:0]     rd_addr_a,
  output logic [ADDR_WIDTH-1:0]     rd_addr_b,
  output logic                      rd_en,
  output logic                      rd_bank,
  output logic [ADDR_WIDTH-2:0]     tw_addr,
  output logic [2*ADDR_WIDTH-1:0]   m_in,
  output logic                      bf_valid,
  output logic                      wr_en,
  output logic [3:0]                stage
);

  localparam int unsigned AW   = ADDR_WIDTH;
  localparam int unsigned CntW = $clog2(BF_LATENCY + 2);
  localparam logic [AW-1:0] KLast = AW'((1 << (AW - 1)) - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              st_q, st_d;
  logic [3:0]          stage_d;
  logic [AW-1:0]       k_q, k_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BF_LATENCY-1:0] wr_pipe;

  logic [AW-1:0] mask, pos, a_d, b_d, tw_full;
  logic          run_d, busy_d;

  always_comb begin
    st_d    = st_q;
    stage_d = stage;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          st_d    = StRun;
          stage_d = '0;
          k_d     = '0;
        end
      end
      StRun: begin
        if (k_q == KLast) begin
          st_d  = StDrain;
          cnt_d = '0;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(BF_LATENCY)) begin
          if (stage == 4'(AW - 1)) begin
            st_d    = StDone;
            stage_d = '0;
          end else begin
            st_d    = StRun;
            stage_d = stage + 4'd1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        // A held start launches the next transform without passing through idle.
        if (start) begin
          st_d    = StRun;
          stage_d = '0;
          k_d     = '0;
        end else begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase

    run_d  = (st_d == StRun);
    busy_d = (st_d == StRun) || (st_d == StDrain);

    // a = grp*2*span + pos: clear the low s bits of k, shift the group index up one.
    mask    = (AW'(1) << stage_d) - AW'(1);
    pos     = k_d & mask;
    a_d     = ((k_d & ~mask) << 1) | pos;
    b_d     = a_d | (AW'(1) << stage_d);
    tw_full = pos << (4'(AW - 1) - stage_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StIdle;
      stage     <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_bank   <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      m_in      <= '0;
      bf_valid  <= 1'b0;
      wr_pipe   <= '0;
    end else begin
      st_q      <= st_d;
      stage     <= stage_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= (st_d == StDone);
      rd_en     <= run_d;
      rd_bank   <= busy_d & stage_d[0];
      rd_addr_a <= run_d ? a_d : '0;
      rd_addr_b <= run_d ? b_d : '0;
      tw_addr   <= run_d ? tw_full[AW-2:0] : '0;
      m_in      <= {rd_addr_b, rd_addr_a};
      bf_valid  <= rd_en;
      wr_pipe   <= (wr_pipe << 1) | BF_LATENCY'(bf_valid);
    end
  end

  assign wr_en = wr_pipe[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl: directed transforms push expected events, monitors pop them.
module tb_fft_stage_ctrl;

  logic clk = 1'b0;
  logic rst, start, start4;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance, ADDR_WIDTH=3
  logic       busy, done, rd_en, rd_bank, bf_valid, wr_en;
  logic [2:0] rd_a, rd_b;
  logic [1:0] tw;
  logic [5:0] m_in;
  logic [3:0] stage;

  fft_stage_ctrl #(.ADDR_WIDTH(3), .BF_LATENCY(3)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr_a(rd_a), .rd_addr_b(rd_b), .rd_en(rd_en), .rd_bank(rd_bank),
    .tw_addr(tw), .m_in(m_in), .bf_valid(bf_valid), .wr_en(wr_en), .stage(stage)
  );

  // 16-point instance
  logic       d4_busy, d4_done, d4_rd_en, d4_rd_bank, d4_bf_valid, d4_wr_en;
  logic [3:0] d4_a, d4_b, d4_stage;
  logic [2:0] d4_tw;
  logic [7:0] d4_m_in;

  fft_stage_ctrl #(.ADDR_WIDTH(4), .BF_LATENCY(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(d4_busy), .done(d4_done),
    .rd_addr_a(d4_a), .rd_addr_b(d4_b), .rd_en(d4_rd_en), .rd_bank(d4_rd_bank),
    .tw_addr(d4_tw), .m_in(d4_m_in), .bf_valid(d4_bf_valid), .wr_en(d4_wr_en),
    .stage(d4_stage)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t q_rd[$], q_m[$], q_wr[$], q_done[$], q_busy[$];
  int  total = 0;
  int  bad   = 0;

  // Hand-computed (a, b, tw) for stages 0..2 of the 8-point transform
  int exp_a[12]  = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b[12]  = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
  int exp_bk[3]  = '{0, 1, 0};

  function automatic void cmp(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endfunction

  function automatic void unexpected(string nm);
    total++;
    bad++;
    $display("FAIL %s: got=event want=none (cycle %0d)", nm, cyc);
  endfunction

  // Expected events of one 8-point transform whose start is sampled in cycle t0,
  // keeping only those that occur no later than cycle lim.
  function automatic void push_run(int t0, int lim);
    for (int i = 0; i < 12; i++) begin
      int s = i / 4;
      int c = t0 + 1 + s * 8 + (i % 4);
      logic [31:0] v;
      v = {19'd0, 4'(s), 1'(exp_bk[s]), 2'(exp_tw[i]), 3'(exp_b[i]), 3'(exp_a[i])};
      if (c <= lim)     q_rd.push_back('{c, v});
      if (c + 1 <= lim) q_m.push_back('{c + 1, {26'd0, 3'(exp_b[i]), 3'(exp_a[i])}});
      if (c + 4 <= lim) q_wr.push_back('{c + 4, 32'd0});
    end
    for (int c = t0 + 1; c <= t0 + 24; c++)
      if (c <= lim) q_busy.push_back('{c, 32'd0});
    if (t0 + 25 <= lim) q_done.push_back('{t0 + 25, 32'd0});
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (rd_en) begin
      if (q_rd.size() == 0) unexpected("rd_en");
      else begin
        e = q_rd.pop_front();
        cmp("rd_en cycle", cyc, e.cyc);
        cmp("rd stage/bank/tw/b/a", {19'd0, stage, rd_bank, tw, rd_b, rd_a}, e.val);
      end
    end
    if (bf_valid) begin
      if (q_m.size() == 0) unexpected("bf_valid");
      else begin
        e = q_m.pop_front();
        cmp("bf_valid cycle", cyc, e.cyc);
        cmp("m_in", {26'd0, m_in}, e.val);
      end
    end
    if (wr_en) begin
      if (q_wr.size() == 0) unexpected("wr_en");
      else begin
        e = q_wr.pop_front();
        cmp("wr_en cycle", cyc, e.cyc);
      end
    end
    if (busy) begin
      if (q_busy.size() == 0) unexpected("busy");
      else begin
        e = q_busy.pop_front();
        cmp("busy cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      if (q_done.size() == 0) unexpected("done");
      else begin
        e = q_done.pop_front();
        cmp("done cycle", cyc, e.cyc);
      end
    end
  end

  int busy4 = 0, rd4 = 0, wr4 = 0, done4 = 0, k4 = 0;

  always @(negedge clk) begin
    if (d4_busy)  busy4++;
    if (d4_rd_en) rd4++;
    if (d4_wr_en) wr4++;
    if (d4_done)  done4++;
    if (d4_rd_en && d4_stage == 4'd3) begin
      cmp("n16 s3 a", {28'd0, d4_a}, k4);
      cmp("n16 s3 b", {28'd0, d4_b}, k4 + 8);
      cmp("n16 s3 tw", {29'd0, d4_tw}, k4);
      k4++;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_drained(string nm);
    cmp({nm, " rd left"}, q_rd.size(), 0);
    cmp({nm, " m left"}, q_m.size(), 0);
    cmp({nm, " wr left"}, q_wr.size(), 0);
    cmp({nm, " busy left"}, q_busy.size(), 0);
    cmp({nm, " done left"}, q_done.size(), 0);
    q_rd.delete(); q_m.delete(); q_wr.delete(); q_busy.delete(); q_done.delete();
  endtask

  task automatic check_quiet(string nm);
    cmp(nm, {busy, done, rd_a, rd_b, rd_en, rd_bank, tw, m_in, bf_valid, wr_en, stage}, 0);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    start = 1'b1;
    start4 = 1'b0;

    // Reset with start asserted: nothing may launch
    tick(2);
    check_quiet("reset outputs");
    rst = 1'b0;
    start = 1'b0;
    tick(5);
    check_quiet("idle after reset");

    // Full default run, 16-point instance in parallel
    t0 = cyc;
    push_run(t0, 1 << 30);
    start = 1'b1;
    start4 = 1'b1;
    tick(1);
    start = 1'b0;
    start4 = 1'b0;
    tick(60);
    check_drained("run8");
    cmp("n16 busy cycles", busy4, 48);
    cmp("n16 rd cycles", rd4, 32);
    cmp("n16 wr cycles", wr4, 32);
    cmp("n16 done pulses", done4, 1);
    cmp("n16 stage3 pairs", k4, 8);

    // start re-pulsed while busy is ignored
    t0 = cyc;
    push_run(t0, 1 << 30);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(11);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    check_drained("repulse");

    // Reset asserted in cycle 10 of a transform
    t0 = cyc;
    push_run(t0, t0 + 10);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    rst = 1'b1;
    tick(1);
    check_quiet("after mid reset");
    rst = 1'b0;
    tick(30);
    check_drained("abort");

    // Fresh transform after the abort
    t0 = cyc;
    push_run(t0, 1 << 30);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(30);
    check_drained("post abort");

    // start held: second transform issues from cycle 26
    t0 = cyc;
    push_run(t0, 1 << 30);
    push_run(t0 + 25, 1 << 30);
    start = 1'b1;
    tick(26);
    start = 1'b0;
    tick(35);
    check_drained("back-to-back");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
